polyveck_power2round_ctrl: RTL

- Sequential, coefficient-serial replacement for the fully parallel vector power2round datapath. It applies Dilithium Power2Round to all K×N coefficients of vector t.
- Reads t from a coefficient RAM with 1-cycle read latency. Instantiates one coefficient-level power2round unit and streams (t1, t0) pairs to a writer over a valid/ready handshake.
- Sits between the t = A·s1 + s2 accumulation store and the t1-pack / t0-pack stages of keygen.

---
 rtl/dilithium_params_pkg.sv | 21 ++
 rtl/coeff_power2round.sv | 30 +++
 rtl/polyveck_power2round_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dilithium_params_pkg.sv
// Shared Dilithium parameters for the keygen datapath blocks.
// Holds the ring/vector dimensions, the Power2Round drop count, the modulus,
// the coefficient and address widths, and the state type of the serial
// power2round controller.
package dilithium_params_pkg;

    localparam int K  = 6;
    localparam int N  = 256;
    localparam int D  = 13;
    localparam int Q  = 8380417;
    localparam int W  = 32;
    localparam int AW = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } p2r_state_t;

endpackage

// File: rtl/coeff_power2round.sv
// Combinational Power2Round of a single coefficient.
// Splits a into a high part t1 and a centred low part t0 with a = t1*2^D + t0.
// No modular reduction is applied; for a in [0, Q) the low part lands in
// (-2^(D-1), 2^(D-1)].
// Ports:
//   a   in  W  coefficient, signed two's complement
//   t1  out W  high part
//   t0  out W  low part, signed
module coeff_power2round #(
    parameter int W = dilithium_params_pkg::W,
    parameter int D = dilithium_params_pkg::D
) (
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] t1,
    output logic signed [W-1:0] t0
);

    // Bias of 2^(D-1)-1 makes the arithmetic shift round half-down, which
    // keeps t0 = +2^(D-1) on the positive side of the centred range.
    localparam logic signed [W-1:0] HALF_M1 = W'((1 << (D - 1)) - 1);

    logic signed [W-1:0] biased;

    always_comb begin
        biased = a + HALF_M1;
        t1     = biased >>> D;
        t0     = a - (t1 <<< D);
    end

endmodule

// File: rtl/polyveck_power2round_ctrl.sv
// Coefficient-serial Power2Round over all K*N coefficients of vector t.
// Reads t from a RAM with one cycle of read latency, splits every coefficient
// with one coeff_power2round unit and streams (t1, t0) pairs with their index
// to a writer over a valid/ready handshake through a 2-entry output FIFO.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, only honoured in IDLE
//   busy, done          run in progress / one-cycle completion pulse
//   rd_en, rd_addr      read strobe and index (poly*N + coeff) to the t RAM
//   rd_data             RAM data, valid one cycle after rd_en
//   wr_valid, wr_ready  output handshake
//   wr_addr             index of the pair at the FIFO head
//   t1_data, t0_data    high and low parts at the FIFO head
module polyveck_power2round_ctrl #(
    parameter int K  = dilithium_params_pkg::K,
    parameter int N  = dilithium_params_pkg::N,
    parameter int D  = dilithium_params_pkg::D,
    parameter int W  = dilithium_params_pkg::W,
    parameter int AW = dilithium_params_pkg::AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic signed [W-1:0] rd_data,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [AW-1:0]       wr_addr,
    output logic signed [W-1:0] t1_data,
    output logic signed [W-1:0] t0_data
);

    import dilithium_params_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(K * N - 1);

    p2r_state_t          state;
    logic [AW-1:0]       rd_idx;
    logic [AW-1:0]       push_idx;
    logic                inflight;
    logic [1:0]          fifo_count;
    logic [1:0]          count_next;
    logic [2:0]          credit;
    logic                push;
    logic                pop;
    logic                drain_done;

    logic [AW-1:0]       head_addr;
    logic signed [W-1:0] head_t1;
    logic signed [W-1:0] head_t0;
    logic [AW-1:0]       tail_addr;
    logic signed [W-1:0] tail_t1;
    logic signed [W-1:0] tail_t0;

    logic signed [W-1:0] calc_t1;
    logic signed [W-1:0] calc_t0;

    coeff_power2round #(
        .W(W),
        .D(D)
    ) u_p2r (
        .a (rd_data),
        .t1(calc_t1),
        .t0(calc_t0)
    );

    // The RAM word returned this cycle is split and pushed immediately.
    assign push = inflight;
    assign pop  = (fifo_count != 2'd0) && wr_ready;

    // A read is only issued if its result is guaranteed a FIFO slot: the
    // in-flight word plus the entries that survive this cycle's pop.
    assign credit = 3'(inflight) + 3'(fifo_count) - 3'(pop);
    assign rd_en  = (state == ST_RUN) && (credit < 3'd2);

    assign count_next = fifo_count + 2'(push) - 2'(pop);

    // In DRAIN no new read can start, so an empty FIFO after this cycle's
    // push/pop means the final handshake is happening now.
    assign drain_done = (count_next == 2'd0);

    assign rd_addr  = rd_idx;
    assign wr_valid = (fifo_count != 2'd0);
    assign wr_addr  = head_addr;
    assign t1_data  = head_t1;
    assign t0_data  = head_t0;

    // Run control: read index, busy and the done pulse are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        rd_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return tracking and the 2-entry output FIFO. The head register
    // drives the write port directly and only moves on a pop, so it stays
    // stable while the writer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            push_idx   <= '0;
            fifo_count <= '0;
            head_addr  <= '0;
            head_t1    <= '0;
            head_t0    <= '0;
            tail_addr  <= '0;
            tail_t1    <= '0;
            tail_t0    <= '0;
        end else begin
            inflight   <= rd_en;
            fifo_count <= count_next;

            if ((state == ST_IDLE) && start) begin
                push_idx <= '0;
            end else if (push) begin
                push_idx <= push_idx + 1'b1;
            end

            if (pop) begin
                if (fifo_count == 2'd2) begin
                    head_addr <= tail_addr;
                    head_t1   <= tail_t1;
                    head_t0   <= tail_t0;
                    if (push) begin
                        tail_addr <= push_idx;
                        tail_t1   <= calc_t1;
                        tail_t0   <= calc_t0;
                    end
                end else if (push) begin
                    head_addr <= push_idx;
                    head_t1   <= calc_t1;
                    head_t0   <= calc_t0;
                end
            end else if (push) begin
                if (fifo_count == 2'd0) begin
                    head_addr <= push_idx;
                    head_t1   <= calc_t1;
                    head_t0   <= calc_t0;
                end else begin
                    tail_addr <= push_idx;
                    tail_t1   <= calc_t1;
                    tail_t0   <= calc_t0;
                end
            end
        end
    end

    // The read credit makes a push into a full FIFO without a pop impossible.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count == 2'd2)));

endmodule
